// File: rtl/mp_add_pkg.sv
// Shared types and constants for the byte-serial multi-precision adder.
package mp_add_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/adder_8.sv
// One byte step of the multi-precision adder: 8-bit sum, carry-out and signed overflow.
module adder_8
   import mp_add_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              ci,
   output logic [BYTE_W-1:0] s,
   output logic              co,
   output logic              of
);

   logic [BYTE_W:0] sum_w;

   assign sum_w = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, ci};
   assign s     = sum_w[BYTE_W-1:0];
   assign co    = sum_w[BYTE_W];
   // Overflow when both operands share a sign that the result does not.
   assign of    = (a[BYTE_W-1] == b[BYTE_W-1]) && (s[BYTE_W-1] != a[BYTE_W-1]);

endmodule

// File: rtl/mp_adder_seq.sv
// Byte-serial add/subtract: walks NBYTES bytes LSB first through one adder_8.
//   state | meaning
//   IDLE  | in_ready=1, waiting for operands
//   RUN   | one byte per cycle through adder_8, carry chained in carry_q
//   DONE  | out_valid=1, result held until out_ready
module mp_adder_seq
   import mp_add_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [8*NBYTES-1:0]     a,
   input  logic [8*NBYTES-1:0]     b,
   input  logic                    ci,
   input  logic                    sub,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [8*NBYTES-1:0]     s,
   output logic                    co,
   output logic                    of
);

   localparam int W  = BYTE_W * NBYTES;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   state_e          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    s_q, s_d;
   logic            co_q, co_d;
   logic            of_q, of_d;

   logic [BYTE_W-1:0] a_byte, b_byte, add_s;
   logic              add_co, add_of;
   logic              last_byte;

   always_comb begin
      a_byte = '0;
      b_byte = '0;
      for (int k = 0; k < NBYTES; k++) begin
         if (idx_q == IW'(k)) begin
            a_byte = a_q[k*BYTE_W +: BYTE_W];
            b_byte = b_q[k*BYTE_W +: BYTE_W];
         end
      end
   end

   adder_8 u_adder_8 (
      .a  (a_byte),
      .b  (b_byte),
      .ci (carry_q),
      .s  (add_s),
      .co (add_co),
      .of (add_of)
   );

   assign last_byte = (idx_q == IW'(NBYTES - 1));
   // in_ready is gated by rst so nothing is accepted while reset is held.
   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign s         = s_q;
   assign co        = co_q;
   assign of        = of_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      co_d    = co_q;
      of_d    = of_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               a_d     = a;
               b_d     = b ^ {W{sub}};
               carry_d = sub | ci;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int k = 0; k < NBYTES; k++) begin
               if (idx_q == IW'(k)) begin
                  s_d[k*BYTE_W +: BYTE_W] = add_s;
               end
            end
            carry_d = add_co;
            if (last_byte) begin
               co_d    = add_co;
               of_d    = add_of;
               state_d = DONE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         co_q    <= 1'b0;
         of_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         co_q    <= co_d;
         of_q    <= of_d;
      end
   end

endmodule
